// File: rtl/rr_next_valid_sched_pkg.sv
// Shared types and constants for the round-robin next-valid scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_next_valid_sched_pkg;

  // Grant FSM: IDLE shows no grant, OFFER holds a registered grant until it is accepted.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // A burst_limit of zero is treated as this value, so every queue gets at least one grant.
  localparam int unsigned BURST_MIN = 1;

endpackage

// File: rtl/rr_wrap_search.sv
// Wrap-around search: returns the first set bit of v strictly after p, ending with p itself.
// Latency: purely combinational.
// Backpressure: none (no state).
module rr_wrap_search #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  v,
  input  logic [SW-1:0] p,
  output logic [SW-1:0] idx,
  output logic          found
);

  logic [W-1:0]  upper_mask;
  logic [W-1:0]  upper;
  logic [W-1:0]  lower;
  logic [SW-1:0] upper_idx;
  logic [SW-1:0] lower_idx;

  // Split v into indices above p (searched first) and indices at or below p (searched after wrap).
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < W; i++) begin
      upper_mask[i] = (SW'(i) > p);
    end
    upper = v & upper_mask;
    lower = v & ~upper_mask;
  end

  // Lowest-index priority encode of each half; scanning downwards lets the lowest set bit win.
  always_comb begin
    upper_idx = '0;
    lower_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (upper[i]) upper_idx = SW'(i);
      if (lower[i]) lower_idx = SW'(i);
    end
    idx   = (|upper) ? upper_idx : lower_idx;
    found = |v;
  end

endmodule

// File: rtl/rr_next_valid_sched.sv
// Round-robin next-valid selector with per-queue burst allowance and valid/ready grant output.
// Latency: 1 cycle from all_valid to sel_valid; back-to-back grants with no bubble while sel_ready=1.
// Backpressure: an offered grant is held unchanged until sel_ready; optional RR_SCHED_PAUSE_MASK_EN adds pause_mask.
module rr_next_valid_sched
  import rr_next_valid_sched_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int SEL_WIDTH   = $clog2(INPUT_WIDTH),
  parameter int BURST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] all_valid,
  input  logic [BURST_WIDTH-1:0] burst_limit,
`ifdef RR_SCHED_PAUSE_MASK_EN
  input  logic [INPUT_WIDTH-1:0] pause_mask,
`endif
  output logic                   sel_valid,
  output logic [SEL_WIDTH-1:0]   sel_index,
  input  logic                   sel_ready,
  output logic                   sel_last
);

  state_t                 state;
  state_t                 state_d;
  logic [SEL_WIDTH-1:0]   ptr;
  logic [SEL_WIDTH-1:0]   ptr_d;
  logic [BURST_WIDTH-1:0] burst_cnt;
  logic [BURST_WIDTH-1:0] cnt_d;
  logic [BURST_WIDTH-1:0] lim;
  logic [BURST_WIDTH:0]   cnt_plus1;
  logic [SEL_WIDTH-1:0]   sel_index_d;
  logic [SEL_WIDTH-1:0]   wrap_idx;
  logic [SEL_WIDTH-1:0]   cand;
  logic [INPUT_WIDTH-1:0] eff_valid;
  logic                   sel_last_d;
  logic                   wrap_found;
  logic                   handshake;
  logic                   search;
  logic                   burst_go;

  assign sel_valid = (state == OFFER);
  assign handshake = sel_valid & sel_ready;
  assign lim       = (burst_limit == '0) ? BURST_WIDTH'(BURST_MIN) : burst_limit;

`ifdef RR_SCHED_PAUSE_MASK_EN
  assign eff_valid = all_valid & ~pause_mask;
`else
  assign eff_valid = all_valid;
`endif

  // Pointer/counter as they stand after any grant accepted this cycle; a new search uses these.
  always_comb begin
    ptr_d  = ptr;
    cnt_d  = burst_cnt;
    search = 1'b0;
    if (state == IDLE) begin
      search = 1'b1;
    end else if (handshake) begin
      search = 1'b1;
      ptr_d  = sel_index;
      if (sel_last) begin
        cnt_d = '0;
      end else if (sel_index == ptr) begin
        cnt_d = (&burst_cnt) ? burst_cnt : burst_cnt + 1'b1;
      end else begin
        cnt_d = BURST_WIDTH'(1);
      end
    end
`ifdef RR_SCHED_PAUSE_MASK_EN
    // A paused queue forfeits whatever is left of its burst.
    if (search && pause_mask[ptr_d]) cnt_d = '0;
`endif
  end

  rr_wrap_search #(
    .W  (INPUT_WIDTH),
    .SW (SEL_WIDTH)
  ) u_wrap (
    .v     (eff_valid),
    .p     (ptr_d),
    .idx   (wrap_idx),
    .found (wrap_found)
  );

  // Next grant: continue the current burst if allowed, else take the wrap-search result.
  always_comb begin
    state_d     = state;
    sel_index_d = sel_index;
    sel_last_d  = sel_last;
    burst_go    = (cnt_d != '0) && (cnt_d < lim) && eff_valid[ptr_d];
    cand        = burst_go ? ptr_d : wrap_idx;
    cnt_plus1   = {1'b0, cnt_d} + 1'b1;
    if (search) begin
      if (wrap_found) begin
        state_d     = OFFER;
        sel_index_d = cand;
        sel_last_d  = (cand == ptr_d) ? (cnt_plus1 >= {1'b0, lim})
                                      : (lim == BURST_WIDTH'(BURST_MIN));
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, pointer, burst counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= SEL_WIDTH'(INPUT_WIDTH - 1);
      burst_cnt <= '0;
      sel_index <= '0;
      sel_last  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      burst_cnt <= cnt_d;
      sel_index <= sel_index_d;
      sel_last  <= sel_last_d;
    end
  end

endmodule

// File: tb/tb_rr_next_valid_sched.sv
// Self-checking bench for rr_next_valid_sched: directed scenarios plus randomized run against a reference model.
// Latency: n/a.
// Backpressure: sel_ready driven directly and randomly.
module tb_rr_next_valid_sched;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] all_valid = '0;
  logic [3:0] burst_limit = 4'd1;
  logic       sel_ready = 1'b0;
  logic [7:0] pm = '0;
  logic       sel_valid;
  logic [2:0] sel_index;
  logic       sel_last;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit m_valid;
  int m_ptr;
  int m_cnt;
  int m_idx;
  bit m_last;

  logic [7:0] hold_seq [4] = '{8'h20, 8'h00, 8'h00, 8'h00};
  int         burst_idx [10] = '{0, 0, 0, 2, 2, 2, 7, 7, 7, 0};
  bit         burst_lst [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  int         pause_idx [5] = '{0, 2, 3, 0, 2};

  always #5 clk = ~clk;

  rr_next_valid_sched #(
    .INPUT_WIDTH (8),
    .SEL_WIDTH   (3),
    .BURST_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .all_valid   (all_valid),
    .burst_limit (burst_limit),
`ifdef RR_SCHED_PAUSE_MASK_EN
    .pause_mask  (pm),
`endif
    .sel_valid   (sel_valid),
    .sel_index   (sel_index),
    .sel_ready   (sel_ready),
    .sel_last    (sel_last)
  );

  // Reference model: grant rules applied directly with integer arithmetic and a linear scan.
  always @(posedge clk) begin : model
    int         lim, p, c, j;
    bit         do_search;
    logic [7:0] v;
    lim = (burst_limit == 0) ? 1 : int'(burst_limit);
`ifdef RR_SCHED_PAUSE_MASK_EN
    v = all_valid & ~pm;
`else
    v = all_valid;
`endif
    if (rst) begin
      m_valid <= 1'b0;
      m_ptr   <= W - 1;
      m_cnt   <= 0;
      m_idx   <= 0;
      m_last  <= 1'b0;
    end else begin
      p = m_ptr;
      c = m_cnt;
      do_search = !m_valid;
      if (m_valid && sel_ready) begin
        do_search = 1'b1;
        p = m_idx;
        if (m_last) c = 0;
        else if (m_idx == m_ptr) c = (c + 1 > 15) ? 15 : c + 1;
        else c = 1;
      end
`ifdef RR_SCHED_PAUSE_MASK_EN
      if (do_search && pm[p]) c = 0;
`endif
      if (do_search) begin
        if (v == 0) begin
          m_valid <= 1'b0;
        end else begin
          j = -1;
          if (c != 0 && c < lim && v[p]) j = p;
          for (int k = 1; k <= W; k++) begin
            if (j < 0 && v[(p + k) % W]) j = (p + k) % W;
          end
          m_valid <= 1'b1;
          m_idx   <= j;
          m_last  <= (j == p) ? (c + 1 >= lim) : (lim == 1);
        end
      end
      m_ptr <= p;
      m_cnt <= c;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    all_valid = '0;
    sel_ready = 1'b0;
    burst_limit = 4'd1;
    pm = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    all_valid = 8'hFF;
    sel_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (sel_valid !== 1'b0 || sel_index !== 3'd0 || sel_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_values: got valid=%b idx=%0d last=%b, want 0/0/0", sel_valid, sel_index, sel_last);
      end
    end
    rst = 1'b0;
    all_valid = '0;
    sel_ready = 1'b0;
  endtask

  task automatic test_idle_then_first();
    do_reset();
    all_valid = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (sel_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_no_valid: cycle %0d got valid=%b, want 0", i, sel_valid);
      end
    end
    all_valid = 8'h01;
    @(negedge clk);
    tests_run++;
    if (sel_valid !== 1'b1 || sel_index !== 3'd0) begin
      tests_failed++;
      $display("FAIL first_grant_latency: got valid=%b idx=%0d, want 1/0", sel_valid, sel_index);
    end
  endtask

  task automatic test_round_robin_l1();
    logic [2:0] exp_idx;
    do_reset();
    all_valid = 8'hFF;
    burst_limit = 4'd1;
    sel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_idx = 3'(i % 8);
      tests_run++;
      if (sel_valid !== 1'b1 || sel_index !== exp_idx || sel_last !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_l1: grant %0d got valid=%b idx=%0d last=%b, want 1/%0d/1", i, sel_valid, sel_index, sel_last, exp_idx);
      end
    end
  endtask

  task automatic test_burst3();
    do_reset();
    all_valid = 8'b1000_0101;
    burst_limit = 4'd3;
    sel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (sel_valid !== 1'b1 || int'(sel_index) != burst_idx[i] || sel_last !== burst_lst[i]) begin
        tests_failed++;
        $display("FAIL burst3: grant %0d got valid=%b idx=%0d last=%b, want 1/%0d/%b", i, sel_valid, sel_index, sel_last, burst_idx[i], burst_lst[i]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    all_valid = 8'h20;
    burst_limit = 4'd1;
    sel_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      all_valid = hold_seq[i];
      @(negedge clk);
      tests_run++;
      if (sel_valid !== 1'b1 || sel_index !== 3'd5 || sel_last !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_offer: cycle %0d got valid=%b idx=%0d last=%b, want 1/5/1", i, sel_valid, sel_index, sel_last);
      end
    end
    sel_ready = 1'b1;
    all_valid = 8'h00;
    @(negedge clk);
    tests_run++;
    if (sel_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_to_idle: got valid=%b, want 0", sel_valid);
    end
    // Pointer now at 5: bits 0 and 6 set must pick 6 (pointer 7 would pick 0).
    sel_ready = 1'b0;
    all_valid = 8'h41;
    @(negedge clk);
    tests_run++;
    if (sel_valid !== 1'b1 || sel_index !== 3'd6) begin
      tests_failed++;
      $display("FAIL hold_ptr_after: got valid=%b idx=%0d, want 1/6", sel_valid, sel_index);
    end
  endtask

  task automatic test_pause();
    do_reset();
    all_valid = 8'h0F;
    pm = 8'h02;
    burst_limit = 4'd1;
    sel_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (sel_valid !== 1'b1 || int'(sel_index) != pause_idx[i]) begin
        tests_failed++;
        $display("FAIL pause_mask: grant %0d got valid=%b idx=%0d, want 1/%0d", i, sel_valid, sel_index, pause_idx[i]);
      end
    end
    pm = '0;
  endtask

  task automatic test_reset_mid_offer();
    int waited;
    do_reset();
    all_valid = 8'h08;
    burst_limit = 4'd2;
    sel_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sel_valid !== 1'b1 || sel_index !== 3'd3) begin
      tests_failed++;
      $display("FAIL pre_reset_offer: got valid=%b idx=%0d, want 1/3", sel_valid, sel_index);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sel_valid !== 1'b0 || sel_index !== 3'd0 || sel_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_offer: got valid=%b idx=%0d last=%b, want 0/0/0", sel_valid, sel_index, sel_last);
    end
    rst = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sel_valid !== 1'b1 && waited < 4);
    tests_run++;
    if (sel_valid !== 1'b1 || sel_index !== 3'd3 || waited != 1) begin
      tests_failed++;
      $display("FAIL reoffer_after_reset: got valid=%b idx=%0d after %0d cycles, want 1/3 after 1", sel_valid, sel_index, waited);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      all_valid = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) burst_limit = 4'($urandom_range(0, 15));
      sel_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
`ifdef RR_SCHED_PAUSE_MASK_EN
      pm = 8'($urandom & $urandom & $urandom);
`endif
      @(negedge clk);
      tests_run++;
      if (sel_valid !== m_valid) begin
        tests_failed++;
        $display("FAIL random_valid: cycle %0d got %b, want %b", i, sel_valid, m_valid);
      end else if (m_valid && (int'(sel_index) != m_idx || sel_last !== m_last)) begin
        tests_failed++;
        $display("FAIL random_grant: cycle %0d got idx=%0d last=%b, want idx=%0d last=%b", i, sel_index, sel_last, m_idx, m_last);
      end
    end
    rst = 1'b0;
    pm = '0;
  endtask

  initial begin
    test_reset();
    test_idle_then_first();
    test_round_robin_l1();
    test_burst3();
    test_hold();
`ifdef RR_SCHED_PAUSE_MASK_EN
    test_pause();
`endif
    test_reset_mid_offer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

endmodule
